// File: rtl/backend_dest_core_buffered.sv
// Per-core write-back stage: update FIFO, local BRAM write, deferred iteration end.
// Optional build macro: BACKEND_COALESCE_EN (merge same-id tail updates by unsigned min).
module backend_dest_core_buffered #(
  parameter int V_ID_WIDTH         = 32,
  parameter int V_VALUE_WIDTH      = 32,
  parameter int ITERATION_WIDTH    = 32,
  parameter int CORE_NUM_WIDTH     = 5,
  parameter int FIFO_DEPTH_LOG     = 4,
  parameter int ALMOST_FULL_MARGIN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [V_ID_WIDTH-1:0]      recv_update_v_id,
  input  logic [V_VALUE_WIDTH-1:0]   recv_update_v_value,
  input  logic                       recv_update_v_valid,
  input  logic                       recv_iteration_end,
  input  logic                       recv_iteration_end_valid,
  input  logic [ITERATION_WIDTH-1:0] recv_iteration_id,
  input  logic                       next_stage_full,
  output logic                       dest_core_full,
  output logic [V_ID_WIDTH-1:0]      wr_vertex_bram_addr,
  output logic [V_VALUE_WIDTH-1:0]   wr_vertex_bram_data,
  output logic                       wr_vertex_bram_valid,
  output logic                       wr_vertex_bram_iteration_end,
  output logic                       wr_vertex_bram_iteration_end_valid,
  output logic [ITERATION_WIDTH-1:0] wr_vertex_bram_iteration_id,
  output logic                       overflow_err
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
  localparam int CW    = FIFO_DEPTH_LOG + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH   = CW'(DEPTH - ALMOST_FULL_MARGIN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_EMIT
  } state_t;

  logic [V_ID_WIDTH-1:0]      r_vid_mem [DEPTH];
  logic [V_VALUE_WIDTH-1:0]   r_val_mem [DEPTH];
  logic [FIFO_DEPTH_LOG-1:0]  r_wr_ptr;
  logic [FIFO_DEPTH_LOG-1:0]  r_rd_ptr;
  logic [CW-1:0]              r_count;
  logic                       r_full;
  logic                       r_ovf;
  logic                       r_wr_valid;
  logic [V_ID_WIDTH-1:0]      r_wr_addr;
  logic [V_VALUE_WIDTH-1:0]   r_wr_data;
  logic [ITERATION_WIDTH-1:0] r_iter_id;
  state_t                     r_state;

  state_t                     w_state_nxt;
  logic                       w_empty;
  logic                       w_fifo_full;
  logic                       w_pop;
  logic                       w_push;
  logic                       w_drop;
  logic                       w_coal;
  logic                       w_capture;
  logic                       w_emit;
  logic [CW-1:0]              w_count_nxt;
  logic [V_ID_WIDTH-1:0]      w_rd_vid;

  assign w_empty     = (r_count == '0);
  assign w_fifo_full = (r_count == DEPTH_C);
  assign w_pop       = !w_empty && !next_stage_full;
  assign w_rd_vid    = r_vid_mem[r_rd_ptr];

`ifdef BACKEND_COALESCE_EN
  logic [FIFO_DEPTH_LOG-1:0] w_tail;
  assign w_tail = r_wr_ptr - 1'b1;
  // Tail is off-limits when this cycle's pop removes it.
  assign w_coal = recv_update_v_valid && !w_empty
               && (r_vid_mem[w_tail] == recv_update_v_id)
               && !(w_pop && (r_count == CW'(1)));
`else
  assign w_coal = 1'b0;
`endif

  assign w_push      = recv_update_v_valid && !w_coal && !w_fifo_full;
  assign w_drop      = recv_update_v_valid && !w_coal && w_fifo_full;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_vid_mem[r_wr_ptr] <= recv_update_v_id;
      r_val_mem[r_wr_ptr] <= recv_update_v_value;
    end
`ifdef BACKEND_COALESCE_EN
    else if (w_coal && (recv_update_v_value < r_val_mem[w_tail])) begin
      r_val_mem[w_tail] <= recv_update_v_value;
    end
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_emit      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (recv_iteration_end && recv_iteration_end_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_empty && !r_wr_valid) w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        w_emit      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_ovf      <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_iter_id  <= '0;
      r_state    <= S_IDLE;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt >= AF_TH);
      r_ovf      <= r_ovf | w_drop;
      r_wr_valid <= w_pop;
      r_wr_addr  <= w_pop ? (w_rd_vid >> CORE_NUM_WIDTH) : '0;
      r_wr_data  <= w_pop ? r_val_mem[r_rd_ptr] : '0;
      if (w_capture) r_iter_id <= recv_iteration_id;
      r_state    <= w_state_nxt;
    end
  end

  assign dest_core_full                     = r_full;
  assign overflow_err                       = r_ovf;
  assign wr_vertex_bram_valid               = r_wr_valid;
  assign wr_vertex_bram_addr                = r_wr_addr;
  assign wr_vertex_bram_data                = r_wr_data;
  assign wr_vertex_bram_iteration_end       = w_emit;
  assign wr_vertex_bram_iteration_end_valid = w_emit;
  assign wr_vertex_bram_iteration_id        = r_iter_id;

endmodule

// File: tb/tb_backend_dest_core_buffered.sv
// Scoreboard bench for backend_dest_core_buffered: queue-level reference model,
// decoupled write/end monitor, directed cases plus randomized traffic.
module tb_backend_dest_core_buffered;
  localparam int CN     = 5;
  localparam int DEPTH  = 16;
  localparam int MARGIN = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] recv_update_v_id;
  logic [31:0] recv_update_v_value;
  logic        recv_update_v_valid;
  logic        recv_iteration_end;
  logic        recv_iteration_end_valid;
  logic [31:0] recv_iteration_id;
  logic        next_stage_full;
  logic        dest_core_full;
  logic [31:0] wr_vertex_bram_addr;
  logic [31:0] wr_vertex_bram_data;
  logic        wr_vertex_bram_valid;
  logic        wr_vertex_bram_iteration_end;
  logic        wr_vertex_bram_iteration_end_valid;
  logic [31:0] wr_vertex_bram_iteration_id;
  logic        overflow_err;

  always #5 clk = ~clk;

  backend_dest_core_buffered dut (
    .clk(clk),
    .rst(rst),
    .recv_update_v_id(recv_update_v_id),
    .recv_update_v_value(recv_update_v_value),
    .recv_update_v_valid(recv_update_v_valid),
    .recv_iteration_end(recv_iteration_end),
    .recv_iteration_end_valid(recv_iteration_end_valid),
    .recv_iteration_id(recv_iteration_id),
    .next_stage_full(next_stage_full),
    .dest_core_full(dest_core_full),
    .wr_vertex_bram_addr(wr_vertex_bram_addr),
    .wr_vertex_bram_data(wr_vertex_bram_data),
    .wr_vertex_bram_valid(wr_vertex_bram_valid),
    .wr_vertex_bram_iteration_end(wr_vertex_bram_iteration_end),
    .wr_vertex_bram_iteration_end_valid(wr_vertex_bram_iteration_end_valid),
    .wr_vertex_bram_iteration_id(wr_vertex_bram_iteration_id),
    .overflow_err(overflow_err)
  );

  typedef struct {
    logic [31:0] k;
    logic [31:0] v;
  } ent_t;

  ent_t        mq[$];
  ent_t        ew[$];
  ent_t        mon_e;
  int          total = 0;
  int          bad = 0;
  bit          pending = 0;
  logic [31:0] exp_iter = '0;
  int          need_w = 0;
  int          pushes = 0;
  int          writes_seen = 0;
  int          end_cnt = 0;
  bit          m_ovf = 0;
  bit          m_df = 0;
  bit          s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_data;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model(bit v, logic [31:0] id, logic [31:0] val,
                       bit em, logic [31:0] it, bit st);
    ent_t e;
    bit   popped;
    bit   coal;
    bit   full;
    popped = (mq.size() > 0) && !st;
    full   = (mq.size() == DEPTH);
    coal   = 0;
`ifdef BACKEND_COALESCE_EN
    if (v && mq.size() > 0 && mq[mq.size()-1].k == id
        && !(popped && mq.size() == 1)) coal = 1;
`endif
    if (coal) begin
      e = mq[mq.size()-1];
      if (val < e.v) e.v = val;
      mq[mq.size()-1] = e;
    end
    if (popped) begin
      e = mq.pop_front();
      ew.push_back('{e.k >> CN, e.v});
    end
    if (v && !coal) begin
      if (full) m_ovf = 1;
      else begin
        mq.push_back('{id, val});
        pushes++;
      end
    end
    if (em && !pending) begin
      pending  = 1;
      exp_iter = it;
      need_w   = pushes;
    end
    m_df = (mq.size() >= DEPTH - MARGIN);
  endtask

  task automatic cyc(bit v, logic [31:0] id, logic [31:0] val,
                     bit em, logic [31:0] it, bit st);
    @(posedge clk);
    #1;
    if (!rst) begin
      chk("dest_core_full", {63'd0, dest_core_full}, {63'd0, m_df});
      chk("overflow_err", {63'd0, overflow_err}, {63'd0, m_ovf});
    end
    s_valid = wr_vertex_bram_valid;
    s_addr  = wr_vertex_bram_addr;
    s_data  = wr_vertex_bram_data;
    #1;
    recv_update_v_valid      = v;
    recv_update_v_id         = id;
    recv_update_v_value      = val;
    recv_iteration_end       = em;
    recv_iteration_end_valid = em;
    recv_iteration_id        = it;
    next_stage_full          = st;
    model(v, id, val, em, it, st);
  endtask

  task automatic clear_model();
    mq.delete();
    ew.delete();
    pending     = 0;
    pushes      = 0;
    writes_seen = 0;
    end_cnt     = 0;
    m_ovf       = 0;
    m_df        = 0;
  endtask

  task automatic do_reset();
    rst                      = 1;
    recv_update_v_valid      = 0;
    recv_update_v_id         = '0;
    recv_update_v_value      = '0;
    recv_iteration_end       = 0;
    recv_iteration_end_valid = 0;
    recv_iteration_id        = '0;
    next_stage_full          = 0;
    clear_model();
    repeat (2) @(posedge clk);
    #2 rst = 0;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_valid"}, {63'd0, wr_vertex_bram_valid}, 64'd0);
    chk({tag, "_addr"}, {32'd0, wr_vertex_bram_addr}, 64'd0);
    chk({tag, "_data"}, {32'd0, wr_vertex_bram_data}, 64'd0);
    chk({tag, "_end"}, {62'd0, wr_vertex_bram_iteration_end,
        wr_vertex_bram_iteration_end_valid}, 64'd0);
    chk({tag, "_iter_id"}, {32'd0, wr_vertex_bram_iteration_id}, 64'd0);
    chk({tag, "_full_ovf"}, {62'd0, dest_core_full, overflow_err}, 64'd0);
  endtask

  task automatic idle(bit st);
    cyc(0, '0, '0, 0, '0, st);
  endtask

  task automatic drain(string tag, int max);
    int n = 0;
    while ((mq.size() > 0 || ew.size() > 0 || pending) && n < max) begin
      idle(0);
      n++;
    end
    chk({tag, "_drain_done"}, {63'd0, (n < max)}, 64'd1);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (wr_vertex_bram_valid) begin
        writes_seen++;
        if (ew.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write actual addr=%0h data=%0h required none",
                   wr_vertex_bram_addr, wr_vertex_bram_data);
        end else begin
          mon_e = ew.pop_front();
          chk("wr_addr", {32'd0, wr_vertex_bram_addr}, {32'd0, mon_e.k});
          chk("wr_data", {32'd0, wr_vertex_bram_data}, {32'd0, mon_e.v});
        end
        chk("no_overlap", {63'd0, wr_vertex_bram_iteration_end}, 64'd0);
      end else begin
        chk("idle_addr_data", {wr_vertex_bram_addr, wr_vertex_bram_data}, 64'd0);
      end
      if (wr_vertex_bram_iteration_end || wr_vertex_bram_iteration_end_valid) begin
        end_cnt++;
        chk("end_valid_pair", {63'd0, wr_vertex_bram_iteration_end_valid},
            {63'd0, wr_vertex_bram_iteration_end});
        if (!pending) begin
          total++;
          bad++;
          $display("FAIL spurious_end actual=1 required=0");
        end else begin
          chk("end_iter_id", {32'd0, wr_vertex_bram_iteration_id}, {32'd0, exp_iter});
          chk("end_after_writes", {63'd0, (writes_seen >= need_w)}, 64'd1);
          pending = 0;
        end
      end
    end
  end

  initial begin
    int vs;
    do_reset();
    check_zero("reset");

    // Latency: 0x45 -> addr 2, valid only two cycles later.
    cyc(1, 32'h45, 32'd7, 0, '0, 0);
    idle(0);
    chk("lat_t1_valid", {63'd0, s_valid}, 64'd0);
    idle(0);
    chk("lat_t2", {s_addr, s_data}, {32'd2, 32'd7});
    chk("lat_t2_valid", {63'd0, s_valid}, 64'd1);
    drain("lat", 20);

    // Almost-full threshold and back-to-back drain.
    for (int i = 0; i < 12; i++) begin
      cyc(1, 32'(i * 32 + 3), 32'(100 + i), 0, '0, 1);
      if (i == 10) chk("df_at_11", {63'd0, dest_core_full}, 64'd0);
    end
    idle(1);
    chk("df_at_12", {63'd0, dest_core_full}, 64'd1);
    idle(0);
    vs = 0;
    for (int i = 0; i < 12; i++) begin
      idle(0);
      vs += int'(s_valid);
    end
    chk("b2b_writes", 64'(vs), 64'd12);
    drain("af", 20);

    // Overflow: 17 distinct ids with stall held.
    for (int i = 0; i < 17; i++) cyc(1, 32'(i * 64 + 1), 32'(i), 0, '0, 1);
    idle(1);
    chk("ovf_set", {63'd0, overflow_err}, 64'd1);
    drain("ovf", 60);
    chk("ovf_sticky", {63'd0, overflow_err}, 64'd1);
    do_reset();
    idle(0);
    chk("ovf_cleared", {63'd0, overflow_err}, 64'd0);

    // End marker in same cycle as the 4th update.
    for (int i = 0; i < 3; i++) cyc(1, 32'(i * 32 + 7), 32'(i + 50), 0, '0, 0);
    cyc(1, 32'h99, 32'd77, 1, 32'd5, 0);
    drain("end4", 40);
    chk("end4_writes", 64'(writes_seen), 64'd4);
    chk("end4_pulses", 64'(end_cnt), 64'd1);

    // Same-id pair under stall.
    do_reset();
    cyc(1, 32'h20, 32'd9, 0, '0, 1);
    cyc(1, 32'h20, 32'd4, 0, '0, 1);
    drain("coal", 30);
`ifdef BACKEND_COALESCE_EN
    chk("coal_writes", 64'(writes_seen), 64'd1);
`else
    chk("coal_writes", 64'(writes_seen), 64'd2);
`endif

    // Reset while draining two queued entries.
    do_reset();
    cyc(1, 32'h40, 32'd1, 0, '0, 1);
    cyc(1, 32'h60, 32'd2, 1, 32'd9, 1);
    idle(1);
    @(posedge clk);
    #2;
    rst = 1;
    clear_model();
    @(posedge clk);
    #1;
    check_zero("mid_rst");
    @(posedge clk);
    #2 rst = 0;
    next_stage_full = 0;
    repeat (20) idle(0);
    chk("mid_rst_no_writes", 64'(writes_seen), 64'd0);
    chk("mid_rst_no_end", 64'(end_cnt), 64'd0);

    // Randomized traffic in phases of differing stall pressure.
    for (int ph = 0; ph < 3; ph++) begin
      do_reset();
      for (int c = 0; c < 700; c++) begin
        bit          v;
        bit          st;
        bit          em;
        logic [31:0] id;
        v  = ($urandom_range(0, 99) < 60);
        st = ($urandom_range(0, 99) < 20 + ph * 15);
        id = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3) * 32) : $urandom;
        em = 0;
        if (!pending && $urandom_range(0, 99) < 3) em = 1;
        if (pending && mq.size() > 0 && $urandom_range(0, 99) < 5) em = 1;
        cyc(v, id, $urandom, em, $urandom, st);
      end
      drain("rand", 200);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
